// File: rtl/burst_spram_if.sv
// burst_spram_if: cache-side mem_* bus between a master and the burst_spram slave.
// Signals: mem_addr/mem_in/mem_rdreq/mem_wrreq/mem_burstlen (master -> slave),
// mem_out/mem_out_valid/mem_busy/mem_in_ack (slave -> master),
// mem_byteen (master -> slave) only when BURST_SPRAM_BYTEEN_EN is defined.
interface burst_spram_if #(
    parameter int DATABITS = 32,
    parameter int ADDRBITS = 32
);
    logic [ADDRBITS-1:0]   mem_addr;
    logic [DATABITS-1:0]   mem_in;
    logic [DATABITS-1:0]   mem_out;
    logic                  mem_out_valid;
    logic                  mem_rdreq;
    logic                  mem_wrreq;
    logic [15:0]           mem_burstlen;
    logic                  mem_busy;
    logic                  mem_in_ack;
`ifdef BURST_SPRAM_BYTEEN_EN
    logic [DATABITS/8-1:0] mem_byteen;
`endif

    modport master (
        output mem_addr, mem_in, mem_rdreq, mem_wrreq, mem_burstlen,
`ifdef BURST_SPRAM_BYTEEN_EN
        output mem_byteen,
`endif
        input  mem_out, mem_out_valid, mem_busy, mem_in_ack
    );

    modport slave (
        input  mem_addr, mem_in, mem_rdreq, mem_wrreq, mem_burstlen,
`ifdef BURST_SPRAM_BYTEEN_EN
        input  mem_byteen,
`endif
        output mem_out, mem_out_valid, mem_busy, mem_in_ack
    );
endinterface

// File: rtl/burst_spram.sv
// burst_spram: single-port RAM slave with read latency, wrapping multi-beat bursts and busy/ack handshake.
// Ports: clk (rising edge), reset_n (async, active low), bus (burst_spram_if.slave).
// Optional: define BURST_SPRAM_BYTEEN_EN to honour per-byte write enables on bus.mem_byteen.
module burst_spram #(
    parameter int DATABITS    = 32,
    parameter int ADDRBITS    = 32,
    parameter int MEMADDRBITS = 9,
    parameter int LATENCY     = 1
) (
    input logic          clk,
    input logic          reset_n,
    burst_spram_if.slave bus
);
    localparam int BYTES = DATABITS / 8;
    localparam int OFS   = $clog2(BYTES);
    localparam logic [MEMADDRBITS-1:0] IDX_ONE = 1;

    typedef enum logic [1:0] {IDLE, RDWAIT, RDBURST, WRBURST} state_t;

    state_t                 state_q, state_d;
    logic [MEMADDRBITS-1:0] idx_q, idx_d, req_idx, wr_idx;
    logic [15:0]            cnt_q, cnt_d, req_len;
    logic [3:0]             wait_q, wait_d;
    logic [DATABITS-1:0]    out_q, out_d;
    logic                   valid_q, valid_d, busy_q;
    logic                   wr_en;
    logic [BYTES-1:0]       be;
    logic                   unused_addr;
    logic [DATABITS-1:0]    ram [2**MEMADDRBITS];

    assign unused_addr = ^bus.mem_addr;

`ifdef BURST_SPRAM_BYTEEN_EN
    assign be = bus.mem_byteen;
`else
    assign be = '1;
`endif

    always_comb begin
        req_idx = bus.mem_addr[MEMADDRBITS+OFS-1:OFS];
        req_len = bus.mem_burstlen == 16'd0 ? 16'd1 : bus.mem_burstlen;
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        out_d   = out_q;
        valid_d = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = idx_q;
        case (state_q)
            IDLE: begin
                // Read has priority; a simultaneous write request is simply dropped.
                if (bus.mem_rdreq) begin
                    idx_d   = req_idx;
                    cnt_d   = req_len;
                    wait_d  = 4'(LATENCY - 1);
                    state_d = LATENCY == 1 ? RDBURST : RDWAIT;
                end else if (bus.mem_wrreq) begin
                    // Beat 0 is written at the accepting edge itself.
                    wr_en   = 1'b1;
                    wr_idx  = req_idx;
                    idx_d   = req_idx + IDX_ONE;
                    cnt_d   = req_len - 16'd1;
                    state_d = req_len == 16'd1 ? IDLE : WRBURST;
                end
            end
            RDWAIT: begin
                wait_d  = wait_q - 4'd1;
                state_d = wait_q == 4'd1 ? RDBURST : RDWAIT;
            end
            RDBURST: begin
                valid_d = 1'b1;
                out_d   = ram[idx_q];
                idx_d   = idx_q + IDX_ONE;
                cnt_d   = cnt_q - 16'd1;
                state_d = cnt_q == 16'd1 ? IDLE : RDBURST;
            end
            WRBURST: begin
                wr_en   = 1'b1;
                idx_d   = idx_q + IDX_ONE;
                cnt_d   = cnt_q - 16'd1;
                state_d = cnt_q == 16'd1 ? IDLE : WRBURST;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            wait_q  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            busy_q  <= state_d != IDLE;
        end
    end

    // Storage is deliberately not reset so words survive a mid-burst reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            for (int b = 0; b < BYTES; b++)
                if (be[b]) ram[wr_idx][8*b +: 8] <= bus.mem_in[8*b +: 8];
    end

    assign bus.mem_out       = out_q;
    assign bus.mem_out_valid = valid_q;
    assign bus.mem_busy      = busy_q;
    assign bus.mem_in_ack    = wr_en;
endmodule
